// File: rtl/nibble_serial_add_arbiter.sv
// Purpose: two-requester round-robin arbiter that adds WIDTH-bit operands one nibble per cycle through an external 4-bit adder.
// Latency: grant pulse one cycle after the grant edge; done pulse N cycles after the grant pulse; back-to-back grants N+2 cycles apart.
// Backpressure: requests are only sampled in IDLE; a request withdrawn before its grant edge is never served.
module nibble_serial_add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_cin,
    input  logic [3:0]       adder_s,
    input  logic             adder_cout
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             last_gnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_nxt;
    logic             grant_any;
    logic             grant_id;
    logic             last_step;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        grant_any = req0 | req1;
        grant_id  = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_gnt;
        end else begin
            grant_id = req1;
        end
        last_step = (idx == IW'(N - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, external adder drive and the result with the current nibble merged in.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        adder_a    = 4'h0;
        adder_b    = 4'h0;
        adder_cin  = 1'b0;
        result_nxt = result;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy      = 1'b1;
                adder_a   = opa[{idx, 2'b00} +: 4];
                adder_b   = opb[{idx, 2'b00} +: 4];
                adder_cin = carry;
                result_nxt[{idx, 2'b00} +: 4] = adder_s;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture at grant, nibble accumulation in ADD, result publish on the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= 2'b00;
            done     <= 1'b0;
            done_id  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            last_gnt <= 1'b1;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt      <= grant_id ? 2'b10 : 2'b01;
                        last_gnt <= grant_id;
                        opa      <= grant_id ? a1 : a0;
                        opb      <= grant_id ? b1 : b0;
                        idx      <= '0;
                        carry    <= 1'b0;
                        result   <= '0;
                    end
                end
                ADD: begin
                    result <= result_nxt;
                    carry  <= adder_cout;
                    idx    <= idx + 1'b1;
                    if (last_step) begin
                        sum     <= result_nxt;
                        cout    <= adder_cout;
                        done    <= 1'b1;
                        done_id <= last_gnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
// Purpose: directed scoreboard bench for nibble_serial_add_arbiter with a behavioural 4-bit adder.
// Latency: expects grant-to-done of N cycles and back-to-back grants N+2 cycles apart.
// Backpressure: withdrawn requests must never be granted; unexpected grants/dones count as failures.
module tb_nibble_serial_add_arbiter;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        cout;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       gnt;
    logic             busy, done, done_id, cout;
    logic [WIDTH-1:0] sum;
    logic [3:0]       adder_a, adder_b, adder_s;
    logic             adder_cin, adder_cout;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   prev_gnt_cyc = 0;
    int   exp_gap  = 0;
    int   gnt0_cnt = 0;
    int   cnt0_snap;
    logic has_prev = 1'b0;
    logic [15:0] held_sum = '0;
    logic        held_cout = 1'b0;
    logic        held_id = 1'b0;

    logic gq[$];
    res_t rq[$];

    nibble_serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .sum        (sum),
        .cout       (cout),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_s    (adder_s),
        .adder_cout (adder_cout)
    );

    // Behavioural external look-ahead adder.
    assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: grants and results are popped from the scoreboard when the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            has_prev  = 1'b0;
            held_sum  = '0;
            held_cout = 1'b0;
            held_id   = 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                if (gnt[0]) gnt0_cnt++;
                if (gq.size() == 0) begin
                    n_checks++;
                    $display("FAIL gnt_unexpected: got %b expected none (t=%0t)", gnt, $time);
                end else begin
                    logic eg;
                    eg = gq.pop_front();
                    check("gnt", {30'b0, gnt}, eg ? 32'd2 : 32'd1);
                end
                if (exp_gap != 0 && has_prev) check("gnt_gap", cyc - prev_gnt_cyc, exp_gap);
                has_prev     = (exp_gap != 0);
                prev_gnt_cyc = cyc;
            end
            if (done) begin
                check("busy_in_done", {31'b0, busy}, 32'd1);
                check("done_latency", cyc - prev_gnt_cyc, N);
                if (rq.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got sum 0x%0h expected no done (t=%0t)", sum, $time);
                end else begin
                    res_t e;
                    e = rq.pop_front();
                    check("sum", {16'b0, sum}, {16'b0, e.sum});
                    check("cout", {31'b0, cout}, {31'b0, e.cout});
                    check("done_id", {31'b0, done_id}, {31'b0, e.id});
                    held_sum  = e.sum;
                    held_cout = e.cout;
                    held_id   = e.id;
                end
            end else begin
                check("hold_sum", {16'b0, sum}, {16'b0, held_sum});
                check("hold_cout", {31'b0, cout}, {31'b0, held_cout});
                check("hold_id", {31'b0, done_id}, {31'b0, held_id});
            end
        end
    end

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) return;
        end
        n_checks++;
        $display("FAIL wait_gnt: got no grant expected one within 20 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_checks++;
        $display("FAIL wait_idle: got busy expected idle within 40 cycles");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, {30'b0, gnt}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_done_id"}, {31'b0, done_id}, 32'd0);
        check({tag, "_sum"}, {16'b0, sum}, 32'd0);
        check({tag, "_cout"}, {31'b0, cout}, 32'd0);
        check({tag, "_adder_a"}, {28'b0, adder_a}, 32'd0);
        check({tag, "_adder_b"}, {28'b0, adder_b}, 32'd0);
        check({tag, "_adder_cin"}, {31'b0, adder_cin}, 32'd0);
    endtask

    // Called on the negedge of the first ADD cycle; walks all N nibble steps.
    task automatic check_add(input logic [15:0] a, input logic [15:0] b, input logic [3:0] cins);
        for (int i = 0; i < N; i++) begin
            check("add_busy", {31'b0, busy}, 32'd1);
            check("adder_a", {28'b0, adder_a}, {28'b0, a[4*i +: 4]});
            check("adder_b", {28'b0, adder_b}, {28'b0, b[4*i +: 4]});
            check("adder_cin", {31'b0, adder_cin}, {31'b0, cins[i]});
            if (i < N - 1) @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected end before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Requester 0: 0x1234 + 0x0FFF = 0x2233, carries 0,1,1,1 into nibbles.
        gq.push_back(1'b0);
        rq.push_back('{1'b0, 16'h2233, 1'b0});
        a0 = 16'h1234; b0 = 16'h0FFF; req0 = 1'b1;
        wait_gnt();
        req0 = 1'b0;
        check_add(16'h1234, 16'h0FFF, 4'b1110);
        wait_idle();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Requester 1: 0xFFFF + 0x0001 wraps to 0 with carry-out.
        gq.push_back(1'b1);
        rq.push_back('{1'b1, 16'h0000, 1'b1});
        a1 = 16'hFFFF; b1 = 16'h0001; req1 = 1'b1;
        wait_gnt();
        req1 = 1'b0;
        check_add(16'hFFFF, 16'h0001, 4'b1110);
        wait_idle();

        // Both requests held from reset: 0, 1, 0 spaced N+2 apart.
        @(posedge clk); #1 rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h0001; b0 = 16'h0002; a1 = 16'h1000; b1 = 16'h2000;
        gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
        rq.push_back('{1'b0, 16'h0003, 1'b0});
        rq.push_back('{1'b1, 16'h3000, 1'b0});
        rq.push_back('{1'b0, 16'h0003, 1'b0});
        exp_gap = N + 2;
        repeat (2) @(negedge clk);
        check_zero("rr_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) wait_gnt();
        req0 = 1'b0; req1 = 1'b0; exp_gap = 0;
        wait_idle();

        // Reset while ADD is at nibble 2: no done, everything cleared.
        @(posedge clk); #1;
        gq.push_back(1'b0);
        a0 = 16'h1234; b0 = 16'h0FFF; req0 = 1'b1;
        wait_gnt();
        req0 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_adder_a", {28'b0, adder_a}, 32'h2);
        check("abort_adder_cin", {31'b0, adder_cin}, 32'd1);
        @(negedge clk);
        check_zero("abort");
        check("abort_no_result", rq.size(), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        gq.push_back(1'b0);
        rq.push_back('{1'b0, 16'h0100, 1'b0});
        a0 = 16'h00A5; b0 = 16'h005B; req0 = 1'b1;
        wait_gnt();
        req0 = 1'b0;
        check_add(16'h00A5, 16'h005B, 4'b0110);
        wait_idle();

        // req0 raised and withdrawn while requester 1 is in flight: never granted.
        gq.push_back(1'b1);
        rq.push_back('{1'b1, 16'h0008, 1'b0});
        a1 = 16'h0005; b1 = 16'h0003; req1 = 1'b1;
        wait_gnt();
        req1 = 1'b0;
        cnt0_snap = gnt0_cnt;
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        req0 = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("dropped_req0_gnt_count", gnt0_cnt, cnt0_snap);

        // req0 held continuously; operands changed after each grant edge.
        exp_gap = N + 2;
        gq.push_back(1'b0); gq.push_back(1'b0); gq.push_back(1'b0);
        rq.push_back('{1'b0, 16'hFFFF, 1'b0});
        rq.push_back('{1'b0, 16'h0000, 1'b1});
        rq.push_back('{1'b0, 16'h1000, 1'b0});
        a0 = 16'h8421; b0 = 16'h7BDE; req0 = 1'b1;
        wait_gnt();
        a0 = 16'hF000; b0 = 16'h1000;
        wait_gnt();
        a0 = 16'h0FFF; b0 = 16'h0001;
        wait_gnt();
        req0 = 1'b0; exp_gap = 0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("gnt_queue_drained", gq.size(), 32'd0);
        check("result_queue_drained", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
